// File: rtl/sprinkler_pkg.sv
// rtl/sprinkler_pkg.sv - shared types and helpers for the sprinkler sequencer
package sprinkler_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  localparam int MAX_ZONES = 64;

  function automatic int zone_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Lowest set bit strictly above cur; cur = -1 yields the lowest set bit, -1 means none.
  function automatic int next_set_above(input logic [MAX_ZONES-1:0] mask, input int cur);
    int r;
    r = -1;
    for (int i = MAX_ZONES - 1; i >= 0; i--) begin
      if (mask[i] && (i > cur)) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/zone_onehot_decoder.sv
// rtl/zone_onehot_decoder.sv - zone index to one-hot valve decoder with enable
module zone_onehot_decoder #(
  parameter int NUM_ZONES = 8,
  parameter int ZONE_W    = 3
) (
  input  logic [ZONE_W-1:0]    idx_i,
  input  logic                 en_i,
  output logic [NUM_ZONES-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < NUM_ZONES; i++) begin
      onehot_o[i] = en_i && (idx_i == ZONE_W'(i));
    end
  end

endmodule

// File: rtl/sprinkler_sequencer.sv
// rtl/sprinkler_sequencer.sv - steps through masked zones with run time and dead-time gaps
module sprinkler_sequencer
  import sprinkler_pkg::*;
#(
  parameter int NUM_ZONES = 8,
  parameter int ZONE_W    = zone_w(NUM_ZONES),
  parameter int TIME_W    = 16,
  parameter int GAP_TICKS = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 tick,
  input  logic                 start,
  input  logic                 stop,
  input  logic [NUM_ZONES-1:0] zone_mask,
  input  logic [TIME_W-1:0]    zone_time,
  output logic [NUM_ZONES-1:0] valve,
  output logic [ZONE_W-1:0]    active_zone,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted
);

  localparam int GAP_W = $clog2(GAP_TICKS + 1);

  state_e                 state_q, state_d;
  logic [NUM_ZONES-1:0]   mask_q, mask_d;
  logic [TIME_W-1:0]      time_q, time_d;
  logic [TIME_W-1:0]      run_cnt_q, run_cnt_d;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
  logic [ZONE_W-1:0]      zone_q, zone_d;
  logic [NUM_ZONES-1:0]   valve_q, valve_d;
  logic                   busy_q, done_q, done_d, aborted_q, aborted_d;

  logic [MAX_ZONES-1:0]   start_mask64, run_mask64;
  int                     first_zone, next_zone;

  always_comb begin
    start_mask64                  = '0;
    start_mask64[NUM_ZONES-1:0]   = zone_mask;
    run_mask64                    = '0;
    run_mask64[NUM_ZONES-1:0]     = mask_q;
    first_zone = next_set_above(start_mask64, -1);
    next_zone  = next_set_above(run_mask64, int'(zone_q));
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    time_d    = time_q;
    run_cnt_d = run_cnt_q;
    gap_cnt_d = gap_cnt_q;
    zone_d    = zone_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // A tick coinciding with an accepted start is deliberately ignored.
        if (start && en) begin
          mask_d = zone_mask;
          time_d = zone_time;
          if ((zone_mask == '0) || (zone_time == '0)) begin
            done_d = 1'b1;
          end else begin
            zone_d    = ZONE_W'(first_zone);
            run_cnt_d = zone_time;
            state_d   = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (!en || stop) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (tick) begin
          run_cnt_d = run_cnt_q - TIME_W'(1);
          if (run_cnt_q == TIME_W'(1)) begin
            if (next_zone >= 0) begin
              state_d   = S_GAP;
              gap_cnt_d = GAP_W'(GAP_TICKS);
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
      S_GAP: begin
        if (!en || stop) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (tick) begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
          if (gap_cnt_q == GAP_W'(1)) begin
            zone_d    = ZONE_W'(next_zone);
            run_cnt_d = time_q;
            state_d   = S_RUN;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  zone_onehot_decoder #(
    .NUM_ZONES (NUM_ZONES),
    .ZONE_W    (ZONE_W)
  ) u_decoder (
    .idx_i    (zone_d),
    .en_i     (state_d == S_RUN),
    .onehot_o (valve_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mask_q    <= '0;
      time_q    <= '0;
      run_cnt_q <= '0;
      gap_cnt_q <= '0;
      zone_q    <= '0;
      valve_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      time_q    <= time_d;
      run_cnt_q <= run_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      zone_q    <= zone_d;
      valve_q   <= valve_d;
      busy_q    <= (state_d != S_IDLE);
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign valve       = valve_q;
  assign active_zone = zone_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign aborted     = aborted_q;

  a_valve_safe: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(valve_q) && ((valve_q == '0) || (state_q == S_RUN)));

endmodule

// File: tb/tb_sprinkler_sequencer.sv
// tb/tb_sprinkler_sequencer.sv - randomized and directed bench against a zone-list reference model
module tb_sprinkler_sequencer;

  localparam int NZ  = 8;
  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, tick = 1'b0, start = 1'b0, stop = 1'b0;
  logic [7:0]  zone_mask = '0;
  logic [15:0] zone_time = '0;
  logic [7:0]  valve;
  logic [2:0]  active_zone;
  logic        busy, done, aborted;

  sprinkler_sequencer #(.NUM_ZONES(NZ), .TIME_W(16), .GAP_TICKS(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .tick(tick), .start(start), .stop(stop),
    .zone_mask(zone_mask), .zone_time(zone_time), .valve(valve),
    .active_zone(active_zone), .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: the sequence is an ordered list of zones, a position, and remaining ticks.
  bit  m_running, m_gap;
  int  m_zones[$];
  int  m_pos, m_rem, m_time, m_zone;
  bit  e_done, e_aborted;

  function automatic void model_reset();
    m_running = 0; m_gap = 0; m_zone = 0; m_pos = 0; m_rem = 0;
    e_done = 0; e_aborted = 0;
    m_zones.delete();
  endfunction

  function automatic void model_step();
    e_done = 0;
    e_aborted = 0;
    if (m_running) begin
      if (!en || stop) begin
        m_running = 0;
        e_aborted = 1;
      end else if (tick) begin
        m_rem--;
        if (m_rem == 0) begin
          if (m_gap) begin
            m_gap = 0;
            m_pos++;
            m_zone = m_zones[m_pos];
            m_rem = m_time;
          end else if (m_pos + 1 < m_zones.size()) begin
            m_gap = 1;
            m_rem = GAP;
          end else begin
            m_running = 0;
            e_done = 1;
          end
        end
      end
    end else if (start && en) begin
      m_time = int'(zone_time);
      m_zones.delete();
      for (int i = 0; i < NZ; i++) if (zone_mask[i]) m_zones.push_back(i);
      if (m_zones.size() == 0 || m_time == 0) begin
        e_done = 1;
      end else begin
        m_running = 1; m_gap = 0; m_pos = 0;
        m_zone = m_zones[0];
        m_rem = m_time;
      end
    end
  endfunction

  function automatic logic [7:0] exp_valve();
    logic [7:0] v;
    v = '0;
    if (m_running && !m_gap) v[m_zone] = 1'b1;
    return v;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".valve"}, 64'(valve), 64'(exp_valve()));
    check({tag, ".zone"}, 64'(active_zone), 64'(m_zone));
    check({tag, ".busy"}, 64'(busy), 64'(m_running));
    check({tag, ".done"}, 64'(done), 64'(e_done));
    check({tag, ".aborted"}, 64'(aborted), 64'(e_aborted));
    check({tag, ".onehot0"}, 64'($onehot0(valve)), 64'(1));
  endtask

  task automatic step(input string tag, input logic s_en, input logic s_start, input logic s_stop,
                      input logic s_tick, input logic [7:0] s_mask, input logic [15:0] s_time);
    en = s_en; start = s_start; stop = s_stop; tick = s_tick;
    zone_mask = s_mask; zone_time = s_time;
    @(posedge clk);
    model_step();
    #1;
    compare_all(tag);
    @(negedge clk);
  endtask

  int cnt01, cnt04, cnt_busy, done_at, idx;

  initial begin
    model_reset();
    @(negedge clk);
    #1;
    check("reset.valve", 64'(valve), 64'(0));
    check("reset.busy", 64'(busy), 64'(0));
    check("reset.zone", 64'(active_zone), 64'(0));
    check("reset.done", 64'(done), 64'(0));
    check("reset.aborted", 64'(aborted), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Two-zone sequence with tick every cycle
    step("seq05.start", 1, 1, 0, 0, 8'h05, 16'd3);
    cnt01 = (valve == 8'h01) ? 1 : 0;
    cnt04 = 0; cnt_busy = busy ? 1 : 0; done_at = -1;
    for (int i = 2; i <= 12; i++) begin
      step("seq05.run", 1, 0, 0, 1, 8'h05, 16'd3);
      if (valve == 8'h01) cnt01++;
      if (valve == 8'h04) cnt04++;
      if (busy) cnt_busy++;
      if (done && done_at < 0) begin
        done_at = i;
        check("seq05.valve_at_done", 64'(valve), 64'(0));
      end
    end
    check("seq05.zone0_cycles", 64'(cnt01), 64'(3));
    check("seq05.zone2_cycles", 64'(cnt04), 64'(3));
    check("seq05.busy_cycles", 64'(cnt_busy), 64'(8));
    check("seq05.done_edge", 64'(done_at), 64'(9));

    // Single top zone, one tick
    step("z7.start", 1, 1, 0, 0, 8'h80, 16'd1);
    check("z7.valve", 64'(valve), 64'(8'h80));
    check("z7.zone", 64'(active_zone), 64'(7));
    step("z7.hold", 1, 0, 0, 0, 8'h80, 16'd1);
    step("z7.tick", 1, 0, 0, 1, 8'h80, 16'd1);
    check("z7.done", 64'(done), 64'(1));

    // Empty mask and zero time complete immediately
    step("mask0.start", 1, 1, 0, 1, 8'h00, 16'd3);
    check("mask0.done", 64'(done), 64'(1));
    step("mask0.after", 1, 0, 0, 1, 8'h00, 16'd3);
    step("time0.start", 1, 1, 0, 1, 8'hFF, 16'd0);
    check("time0.done", 64'(done), 64'(1));
    step("time0.after", 1, 0, 0, 1, 8'hFF, 16'd0);

    // Abort by stop and by en drop while on zone 2
    for (int k = 0; k < 2; k++) begin
      step("abort.start", 1, 1, 0, 0, 8'h0F, 16'd2);
      idx = 0;
      while (!(valve == 8'h04) && idx < 40) begin
        step("abort.run", 1, 0, 0, 1, 8'h0F, 16'd2);
        idx++;
      end
      check("abort.reached_zone2", 64'(valve), 64'(8'h04));
      if (k == 0) step("abort.stop", 1, 0, 1, 0, 8'h0F, 16'd2);
      else        step("abort.en", 0, 0, 0, 0, 8'h0F, 16'd2);
      check("abort.pulse", 64'(aborted), 64'(1));
      check("abort.no_done", 64'(done), 64'(0));
    end
    step("en0.start", 0, 1, 0, 1, 8'h0F, 16'd2);
    check("en0.ignored", 64'(busy), 64'(0));
    step("idle.stop", 1, 0, 1, 0, 8'h0F, 16'd2);

    // Tick with start and repeated start while busy
    step("restart.start", 1, 1, 0, 1, 8'h01, 16'd3);
    cnt01 = (valve == 8'h01) ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      step("restart.run", 1, 1, 0, 1, 8'h02, 16'd5);
      if (valve == 8'h01) cnt01++;
    end
    check("restart.zone0_cycles", 64'(cnt01), 64'(3));

    // Asynchronous reset mid-run
    step("rst.start", 1, 1, 0, 0, 8'h02, 16'd5);
    step("rst.run", 1, 0, 0, 1, 8'h02, 16'd5);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst.valve", 64'(valve), 64'(0));
    check("rst.busy", 64'(busy), 64'(0));
    check("rst.zone", 64'(active_zone), 64'(0));
    check("rst.done", 64'(done), 64'(0));
    check("rst.aborted", 64'(aborted), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Random soak
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] r_mask;
      r_mask = 8'($urandom);
      if ($urandom_range(0, 7) == 0) r_mask = 8'h00;
      step("soak", ($urandom_range(0, 19) != 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0),
           r_mask, 16'($urandom_range(0, 4)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
